wb_reg_file: RTL and testbench
==============================

# wb_reg_file

Write-back stage and 16 x 16-bit register file for the 16-bit pipelined datapath, sitting directly downstream of the MEM/WB pipeline buffer. It consumes that buffer's outputs and selects the write-back value (ALU result or memory data). It commits that value to the destination register, with a second write of the ALU upper half into R0 for multiply/divide. It serves the decode stage's two asynchronous read ports and keeps a retired-instruction counter.

## Interface
Parameters:
- NREG, 16, number of registers (address width 4)
- DW, 16, data width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- halt  in  1  1 = stage frozen: no register writes, counter holds
- write_back_ctrl_sgnl  in  16  from MEM/WB buffer:
  - bit0 reg_write
  - bit1 mem_to_reg
  - bit2 write_upper
  - bits[15:3] ignored
- alu_result_bottom_half  in  16  ALU result low half
- alu_result_top_half  in  16  ALU result high half (mul product high / div remainder)
- memory_data_in  in  16  data memory read value
- inst_buff_in  in  16  retiring instruction; dest register = inst_buff_in[11:8]
- rd_addr_a, rd_addr_b  in  4  decode-stage read addresses
- rd_data_a, rd_data_b  out  16  read data
- wb_data  out  16  selected write-back value (to forwarding unit)
- wb_dest  out  4  inst_buff_in[11:8]
- wb_en  out  1  reg_write & ~halt
- retired_count  out  16  retired-instruction counter

## Operation
- wb_data = mem_to_reg ? memory_data_in : alu_result_bottom_half (combinational).
- Write enable: at rising clk with rst=1, halt=0, reg_write=1: reg[wb_dest] <= wb_data.
- Upper write: same edge, if halt=0 and write_upper=1: reg[0] <= alu_result_top_half. Independent of reg_write.
- Conflict: wb_dest=0 with both reg_write and write_upper set -> upper-half write wins; R0 gets alu_result_top_half.
- Reads: rd_data_x = reg[rd_addr_x], combinational, old value during a same-cycle write (unless bypass, see Configuration).
- Counter: increments by 1 at each edge with halt=0 and inst_buff_in != 16'h0000 (0x0000 = NOP/bubble). Wraps 0xFFFF -> 0x0000.
- halt=1: all registers and counter hold. Combinational outputs still track inputs; wb_en=0.

## Timing
- Reset (rst=0, asynchronous, no clock needed):
  - all 16 registers = 0x0000
  - retired_count = 0x0000
  - rd_data_a/b = 0x0000 immediately
- Reset deassertion is synchronous-safe: first write occurs at the first rising edge with rst=1.
- Reset asserted mid-operation aborts any pending write. Register contents are 0 until the next qualifying edge.
- Write latency: value written at edge N is visible on rd_data at N + small delta (same cycle after the edge).
- Counter value visible one edge after the qualifying cycle.
- No handshake: the upstream buffer holds inputs stable for the full cycle. halt is sampled only at the rising edge.

## Configuration
- WB_BYPASS_EN defined: write-through bypass.
  - If wb_en=1 and rd_addr_x == wb_dest, rd_data_x = wb_data in the same cycle, before the edge.
  - The bypass also applies to R0 upper writes: write_upper & ~halt & rd_addr_x==0 gives alu_result_top_half, which takes priority.
- WB_BYPASS_EN undefined: reads return stored contents only. The decode stage must stall one cycle for read-after-write hazards.

## Test plan
- Reset: drive rst=0 mid-cycle after writes -> all rd_data = 0x0000 and retired_count = 0 without a clock edge.
- Basic write: reg_write=1, mem_to_reg=0, alu_result_bottom_half=0xDDDD, inst=0x0500.
  - Then ctrl=0x0003, memory_data_in=0xEEEE, inst=0x0600.
  - Expect R5=0xDDDD, R6=0xEEEE, retired_count=2.
- Halt: halt=1, ctrl=0x0001, inst=0x0700, data 0xCCCC for 2 edges -> R7 unchanged (0x0000), wb_en=0, count unchanged. Releasing halt writes 0xCCCC at the next edge.
- Mul/div: ctrl=0x0005, bottom=0x5555, top=0x1234, inst=0x0300 -> R3=0x5555, R0=0x1234.
  - Repeat with inst=0x0000-dest variant 0x0000 plus ctrl 0x0005 -> R0=0x1234 (upper wins), count unchanged (NOP).
- Counter wrap: preload via 0xFFFF non-NOP instructions (or force) -> 0xFFFF then 0x0000.
- Bypass (WB_BYPASS_EN): rd_addr_a=4 while writing 0xBBBB to R4 -> rd_data_a=0xBBBB before the edge. Without the macro, old value before the edge and 0xBBBB after.

Source files
------------

// File: rtl/wb_reg_file.sv
// Write-back stage and 16 x 16-bit register file with a retired-instruction counter.
// Optional macro WB_BYPASS_EN: same-cycle write-through from the write-back value to the read ports.
module wb_reg_file #(
  parameter int NREG = 16,
  parameter int DW   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    halt,
  input  logic [15:0]             write_back_ctrl_sgnl,
  input  logic [DW-1:0]           alu_result_bottom_half,
  input  logic [DW-1:0]           alu_result_top_half,
  input  logic [DW-1:0]           memory_data_in,
  input  logic [15:0]             inst_buff_in,
  input  logic [$clog2(NREG)-1:0] rd_addr_a,
  input  logic [$clog2(NREG)-1:0] rd_addr_b,
  output logic [DW-1:0]           rd_data_a,
  output logic [DW-1:0]           rd_data_b,
  output logic [DW-1:0]           wb_data,
  output logic [$clog2(NREG)-1:0] wb_dest,
  output logic                    wb_en,
  output logic [15:0]             retired_count
);

  localparam int AW = $clog2(NREG);

  logic          reg_write;
  logic          mem_to_reg;
  logic          write_upper;
  logic          upper_en;
  logic          retire;
  logic          unused_ctrl;
  logic [DW-1:0] regs [NREG];
  logic [15:0]   cnt_q;

  assign reg_write   = write_back_ctrl_sgnl[0];
  assign mem_to_reg  = write_back_ctrl_sgnl[1];
  assign write_upper = write_back_ctrl_sgnl[2];
  assign unused_ctrl = ^write_back_ctrl_sgnl[15:3];

  assign wb_data  = mem_to_reg ? memory_data_in : alu_result_bottom_half;
  assign wb_dest  = inst_buff_in[8 +: AW];
  assign wb_en    = reg_write & ~halt;
  assign upper_en = write_upper & ~halt;
  // An all-zero instruction word is a pipeline bubble and does not retire.
  assign retire   = ~halt & (inst_buff_in != 16'h0000);

  // The upper-half write to R0 is issued last so it wins over a reg_write to R0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (wb_en) begin
        regs[wb_dest] <= wb_data;
      end
      if (upper_en) begin
        regs[0] <= alu_result_top_half;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 16'h0000;
    end else if (retire) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign retired_count = cnt_q;

  always_comb begin
    rd_data_a = regs[rd_addr_a];
    rd_data_b = regs[rd_addr_b];
`ifdef WB_BYPASS_EN
    if (wb_en && (rd_addr_a == wb_dest)) rd_data_a = wb_data;
    if (wb_en && (rd_addr_b == wb_dest)) rd_data_b = wb_data;
    if (upper_en && (rd_addr_a == '0))   rd_data_a = alu_result_top_half;
    if (upper_en && (rd_addr_b == '0))   rd_data_b = alu_result_top_half;
`else
    // Stored contents only; decode stalls one cycle on read-after-write.
`endif
  end

endmodule

// File: tb/tb_wb_reg_file.sv
// Self-checking bench for wb_reg_file: directed vector table, corner sequences, random vs reference model.
module tb_wb_reg_file;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        halt = 1'b0;
  logic [15:0] ctrl = '0;
  logic [15:0] bot = '0, top = '0, mem = '0, inst = '0;
  logic [3:0]  ra = '0, rb = '0;
  logic [15:0] rd_a, rd_b, wbd, cnt;
  logic [3:0]  wdest;
  logic        wen;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  wb_reg_file dut (
    .clk(clk), .rst(rst), .halt(halt),
    .write_back_ctrl_sgnl(ctrl),
    .alu_result_bottom_half(bot), .alu_result_top_half(top),
    .memory_data_in(mem), .inst_buff_in(inst),
    .rd_addr_a(ra), .rd_addr_b(rb),
    .rd_data_a(rd_a), .rd_data_b(rd_b),
    .wb_data(wbd), .wb_dest(wdest), .wb_en(wen),
    .retired_count(cnt)
  );

  typedef struct {
    logic        halt;
    logic [15:0] ctrl, bot, top, mem, inst;
    logic [3:0]  ra, rb;
    logic [15:0] e_wbd;
    logic        e_wen;
    logic [15:0] e_a, e_b, e_cnt;
  } vec_t;

  vec_t vecs [8];

  logic [15:0] mdl [16];
  logic [15:0] mcnt;
  bit          byp;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic h, input logic [15:0] c, b, t, m, i, input logic [3:0] a, bb);
    halt = h; ctrl = c; bot = b; top = t; mem = m; inst = i; ra = a; rb = bb;
  endtask

  // Expected combinational read, including same-cycle bypass when built with it.
  function automatic logic [15:0] exp_rd(input logic [3:0] addr);
    logic [15:0] v;
    v = mdl[addr];
    if (byp) begin
      if (ctrl[0] && !halt && addr == inst[11:8]) v = ctrl[1] ? mem : bot;
      if (ctrl[2] && !halt && addr == 4'd0) v = top;
    end
    return v;
  endfunction

  task automatic model_step();
    if (!halt) begin
      if (ctrl[0]) mdl[inst[11:8]] = ctrl[1] ? mem : bot;
      if (ctrl[2]) mdl[0] = top;
      if (inst != 16'h0000) mcnt = mcnt + 16'd1;
    end
  endtask

  initial begin
`ifdef WB_BYPASS_EN
    byp = 1'b1;
`else
    byp = 1'b0;
`endif
    //           halt ctrl     bot      top      mem      inst     ra  rb  e_wbd    wen  e_a      e_b      e_cnt
    vecs[0] = '{1'b0, 16'h0001, 16'hDDDD, 16'h0000, 16'h0000, 16'h0500, 4'd5, 4'd0, 16'hDDDD, 1'b1, 16'hDDDD, 16'h0000, 16'd1};
    vecs[1] = '{1'b0, 16'h0003, 16'h1111, 16'h0000, 16'hEEEE, 16'h0600, 4'd6, 4'd5, 16'hEEEE, 1'b1, 16'hEEEE, 16'hDDDD, 16'd2};
    vecs[2] = '{1'b1, 16'h0001, 16'hCCCC, 16'h0000, 16'h0000, 16'h0700, 4'd7, 4'd6, 16'hCCCC, 1'b0, 16'h0000, 16'hEEEE, 16'd2};
    vecs[3] = '{1'b1, 16'h0001, 16'hCCCC, 16'h0000, 16'h0000, 16'h0700, 4'd7, 4'd6, 16'hCCCC, 1'b0, 16'h0000, 16'hEEEE, 16'd2};
    vecs[4] = '{1'b0, 16'h0001, 16'hCCCC, 16'h0000, 16'h0000, 16'h0700, 4'd7, 4'd5, 16'hCCCC, 1'b1, 16'hCCCC, 16'hDDDD, 16'd3};
    vecs[5] = '{1'b0, 16'h0005, 16'h5555, 16'h1234, 16'h0000, 16'h0300, 4'd3, 4'd0, 16'h5555, 1'b1, 16'h5555, 16'h1234, 16'd4};
    vecs[6] = '{1'b0, 16'hFFF5, 16'h7777, 16'h4321, 16'h0000, 16'h0000, 4'd0, 4'd3, 16'h7777, 1'b1, 16'h4321, 16'h5555, 16'd4};
    vecs[7] = '{1'b0, 16'h0004, 16'h0000, 16'hABCD, 16'h9999, 16'h0900, 4'd9, 4'd0, 16'h0000, 1'b0, 16'h0000, 16'hABCD, 16'd5};

    // Reset state with no clock edge yet.
    #2;
    chk("reset_rd_a", rd_a, 16'h0000);
    chk("reset_rd_b", rd_b, 16'h0000);
    chk("reset_cnt", cnt, 16'h0000);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[k]) begin
      drive(vecs[k].halt, vecs[k].ctrl, vecs[k].bot, vecs[k].top, vecs[k].mem, vecs[k].inst, vecs[k].ra, vecs[k].rb);
      #1;
      chk($sformatf("vec%0d_wb_data", k), wbd, vecs[k].e_wbd);
      chk($sformatf("vec%0d_wb_en", k), {15'd0, wen}, {15'd0, vecs[k].e_wen});
      chk($sformatf("vec%0d_wb_dest", k), {12'd0, wdest}, {12'd0, vecs[k].inst[11:8]});
      @(posedge clk); #1;
      chk($sformatf("vec%0d_rd_a", k), rd_a, vecs[k].e_a);
      chk($sformatf("vec%0d_rd_b", k), rd_b, vecs[k].e_b);
      chk($sformatf("vec%0d_cnt", k), cnt, vecs[k].e_cnt);
      @(negedge clk);
    end

    // Bypass / read-before-write: R4 is 0, R0 is ABCD going in.
    drive(1'b0, 16'h0005, 16'hBBBB, 16'h5A5A, 16'h0000, 16'h0400, 4'd4, 4'd0);
    #1;
    chk("byp_pre_a", rd_a, byp ? 16'hBBBB : 16'h0000);
    chk("byp_pre_b", rd_b, byp ? 16'h5A5A : 16'hABCD);
    @(posedge clk); #1;
    chk("byp_post_a", rd_a, 16'hBBBB);
    chk("byp_post_b", rd_b, 16'h5A5A);
    chk("byp_cnt", cnt, 16'd6);

    // Counter wrap: preload near the top, then retire two instructions.
    @(negedge clk);
    force dut.cnt_q = 16'hFFFE;
    #1;
    release dut.cnt_q;
    drive(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 4'd5, 4'd0);
    #1;
    chk("wrap_pre", cnt, 16'hFFFE);
    @(posedge clk); #1;
    chk("wrap_ffff", cnt, 16'hFFFF);
    @(posedge clk); #1;
    chk("wrap_zero", cnt, 16'h0000);

    // Asynchronous reset in the middle of the low phase.
    @(negedge clk);
    drive(1'b0, 16'h0001, 16'h3333, 16'h0000, 16'h0000, 16'h0500, 4'd5, 4'd0);
    #1;
    chk("prerst_rd_a", rd_a, byp ? 16'h3333 : 16'hDDDD);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_rd_a", rd_a, byp ? 16'h3333 : 16'h0000);
    chk("midrst_rd_b", rd_b, 16'h0000);
    chk("midrst_cnt", cnt, 16'h0000);
    ctrl = 16'h0000;
    #1;
    chk("midrst_rd_a_idle", rd_a, 16'h0000);
    @(posedge clk); #1;
    chk("rst_held_cnt", cnt, 16'h0000);
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic against the reference model.
    foreach (mdl[r]) mdl[r] = 16'h0000;
    mcnt = 16'h0000;
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 3) == 0), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
            ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom), 4'($urandom), 4'($urandom));
      #1;
      chk("rnd_wb_data", wbd, ctrl[1] ? mem : bot);
      chk("rnd_wb_en", {15'd0, wen}, {15'd0, ctrl[0] & ~halt});
      chk("rnd_wb_dest", {12'd0, wdest}, {12'd0, inst[11:8]});
      chk("rnd_rd_a", rd_a, exp_rd(ra));
      chk("rnd_rd_b", rd_b, exp_rd(rb));
      chk("rnd_cnt", cnt, mcnt);
      @(posedge clk);
      model_step();
      @(negedge clk);
    end
    ctrl = 16'h0000;
    for (int r = 0; r < 16; r++) begin
      ra = 4'(r);
      #1;
      chk($sformatf("final_r%0d", r), rd_a, mdl[r]);
    end
    chk("final_cnt", cnt, mcnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
